lcd_cmd_arbiter: RTL and testbench
==================================

LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- INIT_DLY, 70, power-up wait cycles before first init command
- SETUP_CYC, 2, cycles rs/data are stable before lcd_en rises
- EN_CYC, 4, cycles lcd_en is high
- HOLD_CYC, 2, cycles rs/data are held after lcd_en falls
- EXEC_CYC, 30, post-write execution wait
- LONG_EXEC_CYC, 100, execution wait for clear (0x01) and home (0x02) commands
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, async active-high reset
- req0 / req1, in, 1, requester 0/1 wants a write
- rs0 / rs1, in, 1, requester register select (0 = command, 1 = character)
- data0 / data1, in, 8, requester byte
- ack0 / ack1, out, 1, one-cycle pulse: request accepted
- init_done, out, 1, power-up sequence complete
- busy, out, 1, not able to accept a request this cycle
- lcd_en, lcd_rs, lcd_rw, out, 1 each, LCD bus strobes
- lcd_data, out, 8, LCD data bus

Function
REQ-004 States SHALL be INIT_WAIT, INIT_CMD, ARB, SETUP, PULSE, HOLD, EXEC.
REQ-005 INIT_WAIT SHALL count INIT_DLY cycles, then enter INIT_CMD.
REQ-006 INIT_CMD SHALL issue 0x38, 0x0F, 0x06, 0x01 in order with rs = 0. Each write SHALL use the SETUP/PULSE/HOLD/EXEC timing. After the fourth EXEC, init_done SHALL rise and the state SHALL become ARB.
REQ-007 In ARB with a request present, the block SHALL latch the winner's rs and data, enter SETUP next cycle, and pulse the winner's ack high for exactly that first SETUP cycle.
REQ-008 Arbitration SHALL be round-robin:
- If both requests are present, the requester not granted last wins.
- If one request is present, it wins.
- After reset, req0 has priority.
REQ-009 A requester SHALL hold req/rs/data stable until its ack. Requests are ignored outside ARB.
REQ-010 The write cycle SHALL be:
- SETUP for SETUP_CYC cycles, lcd_en = 0
- PULSE for EN_CYC cycles, lcd_en = 1
- HOLD for HOLD_CYC cycles, lcd_en = 0
- EXEC for EXEC_CYC cycles, or LONG_EXEC_CYC when rs = 0 and data is 0x01 or 0x02
- then return to ARB
REQ-011 lcd_rs and lcd_data SHALL hold the latched values from SETUP through HOLD. lcd_rw SHALL be 0 always.
REQ-012 busy SHALL be 1 in every state except ARB with init_done = 1.
REQ-013 A single 16-bit down-counter SHALL time all phases. A phase ends when the counter reaches 0. A parameter value of 0 SHALL be treated as 1.
REQ-014 When a request arrives in the same cycle EXEC ends, the block SHALL enter ARB first, so ack comes no earlier than the cycle after ARB.
REQ-015 Back-to-back grants with both requesters asserting continuously SHALL alternate 0,1,0,1.

Reset
REQ-016 Reset SHALL immediately set the state to INIT_WAIT, the counter to INIT_DLY, and the last-grant pointer so that req0 has priority next.
REQ-017 Reset SHALL immediately drive these outputs low: lcd_en, lcd_rs, lcd_rw, lcd_data (0x00), ack0, ack1, init_done. busy SHALL be 1.
REQ-018 Reset mid-pulse SHALL drop lcd_en in the same cycle. The full init sequence SHALL rerun afterward.

Structure
REQ-019 A shared package lcd_pkg SHALL hold:
- the state enum
- init command constants (0x38, 0x0F, 0x06, 0x01)
- CLEAR/HOME opcodes
- default timing values
REQ-020 Round-robin selection SHALL be one sub-module, lcd_rr_arb2: two reqs in, one-hot grant out, pointer updated on accept.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, no requests: lcd_en pulses exactly 4 times, with data 0x38, 0x0F, 0x06, 0x01, rs = 0. The 0x01 write is followed by a 100-cycle EXEC. init_done rises at cycle 70 + 3*38 + 108 (= 292) after reset release.
- req0 held with rs0 = 1, data0 = 0x41 after init: ack0 pulses once, lcd_data = 0x41 and lcd_rs = 1 over 8 cycles, lcd_en high 4 cycles, busy for 38 cycles.
- req0 and req1 held continuously: acks alternate 0,1,0,1 with 38-cycle spacing.
- req1 with rs1 = 0, data1 = 0x01: EXEC lasts 100 cycles before the next ack.
- Reset asserted during PULSE: lcd_en low in the same cycle, init sequence restarts from INIT_WAIT.
- Request asserted during init: no ack until init_done = 1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command arbiter: FSM states, HD44780 init
// opcodes, default phase timings and the phase-length clamp.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_INIT_CMD,
    ST_ARB,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON  = 8'h0F;
  localparam logic [7:0] INIT_ENTRY    = 8'h06;
  localparam logic [7:0] INIT_CLEAR    = 8'h01;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int DEF_INIT_DLY      = 70;
  localparam int DEF_SETUP_CYC     = 2;
  localparam int DEF_EN_CYC        = 4;
  localparam int DEF_HOLD_CYC      = 2;
  localparam int DEF_EXEC_CYC      = 30;
  localparam int DEF_LONG_EXEC_CYC = 100;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_FUNC_SET;
      2'd1:    return INIT_DISP_ON;
      2'd2:    return INIT_ENTRY;
      default: return INIT_CLEAR;
    endcase
  endfunction

  // A zero-length phase would never terminate on the down-counter, so clamp to 1.
  function automatic logic [15:0] phase_len(input int cyc);
    if (cyc <= 0)
      return 16'd1;
    else if (cyc > 65535)
      return 16'hFFFF;
    else
      return cyc[15:0];
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances only on accept.
module lcd_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11)
      o_grant = r_last ? 2'b01 : 2'b10;
  end

  // r_last = 1 means requester 1 was served last, so requester 0 goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_last <= 1'b1;
    else if (i_accept && (o_grant != 2'b00))
      r_last <= o_grant[1];
  end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Shares one HD44780-style LCD write port between two requesters after
// running the power-up init sequence; all phases timed by one down-counter.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int INIT_DLY      = DEF_INIT_DLY,
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int EN_CYC        = DEF_EN_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  lcd_state_e  r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic        r_rs;
  logic [7:0]  r_data;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_init_done;

  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_cnt_end;
  logic        w_on_bus;
  logic [15:0] w_exec_len;

  assign w_accept  = (r_state == ST_ARB) && (req0 || req1);
  assign w_cnt_end = (r_cnt <= 16'd1);
  assign w_on_bus  = (r_state == ST_INIT_CMD) || (r_state == ST_SETUP) ||
                     (r_state == ST_PULSE)    || (r_state == ST_HOLD);

  assign w_exec_len = (!r_rs && ((r_data == CMD_CLEAR) || (r_data == CMD_HOME)))
                      ? phase_len(LONG_EXEC_CYC) : phase_len(EXEC_CYC);

  lcd_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({req1, req0}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Outputs decode from state so reset forces them low without waiting a clock.
  assign lcd_en    = (r_state == ST_PULSE);
  assign lcd_rs    = w_on_bus ? r_rs : 1'b0;
  assign lcd_data  = w_on_bus ? r_data : 8'h00;
  assign lcd_rw    = 1'b0;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign init_done = r_init_done;
  assign busy      = !((r_state == ST_ARB) && r_init_done);

  // INIT_CMD doubles as the setup phase for the four init writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT_WAIT;
      r_cnt       <= phase_len(INIT_DLY);
      r_idx       <= 2'd0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_INIT_WAIT: begin
          if (w_cnt_end) begin
            r_state <= ST_INIT_CMD;
            r_cnt   <= phase_len(SETUP_CYC);
            r_rs    <= 1'b0;
            r_data  <= init_cmd(r_idx);
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_INIT_CMD, ST_SETUP: begin
          if (w_cnt_end) begin
            r_state <= ST_PULSE;
            r_cnt   <= phase_len(EN_CYC);
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_ARB: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_cnt   <= phase_len(SETUP_CYC);
            r_rs    <= w_grant[1] ? rs1 : rs0;
            r_data  <= w_grant[1] ? data1 : data0;
            r_ack0  <= w_grant[0];
            r_ack1  <= w_grant[1];
          end
        end
        ST_PULSE: begin
          if (w_cnt_end) begin
            r_state <= ST_HOLD;
            r_cnt   <= phase_len(HOLD_CYC);
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_HOLD: begin
          if (w_cnt_end) begin
            r_state <= ST_EXEC;
            r_cnt   <= w_exec_len;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_EXEC: begin
          if (!w_cnt_end) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (r_init_done) begin
            r_state <= ST_ARB;
          end else if (r_idx == 2'd3) begin
            r_state     <= ST_ARB;
            r_init_done <= 1'b1;
          end else begin
            r_state <= ST_INIT_CMD;
            r_idx   <= r_idx + 2'd1;
            r_cnt   <= phase_len(SETUP_CYC);
            r_data  <= init_cmd(r_idx + 2'd1);
          end
        end
        default: r_state <= ST_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed plus randomized bench for lcd_cmd_arbiter with an event-level model.
module tb_lcd_cmd_arbiter;

  localparam int P_INIT  = 70;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 30;
  localparam int P_LONG  = 100;
  localparam int W_SHORT = P_SETUP + P_EN + P_HOLD + P_EXEC;
  localparam int W_LONG  = P_SETUP + P_EN + P_HOLD + P_LONG;
  localparam int T_INIT  = P_INIT + 3 * W_SHORT + W_LONG;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, rs0, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, init_done, busy, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_cmd_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
    .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1), .init_done(init_done),
    .busy(busy), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // Event monitor: lcd_en rising edges, pulse widths and acks.
  logic       prev_en;
  int         en_len;
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  logic       rise_rs[$];
  int         en_runs[$];
  int         ack_cyc[$];
  int         rw_bad = 0;
  int         both_ack = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_en = 1'b0;
      en_len  = 0;
    end else begin
      if (lcd_en && !prev_en) begin
        rise_cyc.push_back(cyc);
        rise_dat.push_back(lcd_data);
        rise_rs.push_back(lcd_rs);
      end
      if (lcd_en) en_len++;
      else if (prev_en) begin
        en_runs.push_back(en_len);
        en_len = 0;
      end
      prev_en = lcd_en;
      if (ack0 || ack1) ack_cyc.push_back(cyc);
      if (ack0 && ack1) both_ack++;
    end
    if (lcd_rw !== 1'b0) rw_bad++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? P_LONG : P_EXEC;
  endfunction

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
  endfunction

  task automatic clear_log();
    rise_cyc.delete(); rise_dat.delete(); rise_rs.delete();
    en_runs.delete(); ack_cyc.delete();
  endtask

  task automatic check_init(input string tag);
    logic [7:0] seq [4];
    seq[0] = 8'h38; seq[1] = 8'h0F; seq[2] = 8'h06; seq[3] = 8'h01;
    chk({tag, "_en_count"}, rise_cyc.size(), 4);
    if (rise_cyc.size() == 4 && en_runs.size() == 4) begin
      chk({tag, "_first_rise"}, rise_cyc[0], P_INIT + P_SETUP);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_data%0d", tag, i), rise_dat[i], seq[i]);
        chk($sformatf("%s_rs%0d", tag, i), rise_rs[i], 0);
        chk($sformatf("%s_enw%0d", tag, i), en_runs[i], P_EN);
        if (i > 0) chk($sformatf("%s_gap%0d", tag, i), rise_cyc[i] - rise_cyc[i-1], W_SHORT);
      end
      chk({tag, "_clear_exec"}, cyc - rise_cyc[3], P_EN + P_HOLD + P_LONG);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int m_last;
    int t0, prev_ack, exp_gap, who, nb, bad;
    logic exp_rs;
    logic [7:0] exp_d;

    reset = 1'b1; req0 = 0; req1 = 0; rs0 = 0; rs1 = 0; data0 = 0; data1 = 0;
    m_last = 1;
    repeat (3) step();
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);

    // Power-up sequence with no requests.
    clear_log();
    reset = 1'b0;
    for (int i = 0; i < 400 && !init_done; i++) step();
    chk("init_done_seen", init_done, 1);
    chk("init_done_cycle", cyc, T_INIT);
    check_init("init");
    chk("init_no_ack", ack_cyc.size(), 0);

    // Single character write from requester 0.
    clear_log();
    rs0 = 1'b1; data0 = 8'h41; req0 = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 50 && !ack0; i++) step();
    chk("s2_ack0", ack0, 1);
    chk("s2_ack_latency", cyc - t0, 1);
    m_last = 0;
    req0 = 1'b0;
    nb = 0; bad = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (nb < P_SETUP + P_EN + P_HOLD && (lcd_data !== 8'h41 || lcd_rs !== 1'b1)) bad++;
      nb++;
      step();
    end
    chk("s2_busy_len", nb, W_SHORT);
    chk("s2_bus_hold", bad, 0);
    chk("s2_ack_count", ack_cyc.size(), 1);
    chk("s2_en_runs", en_runs.size(), 1);
    if (en_runs.size() == 1) chk("s2_en_width", en_runs[0], P_EN);

    // Clear command from requester 1 followed by a second request.
    rs1 = 1'b0; data1 = 8'h01; req1 = 1'b1;
    for (int i = 0; i < 50 && !ack1; i++) step();
    chk("s4_ack1", ack1, 1);
    chk("s4_data", lcd_data, 8'h01);
    m_last = 1;
    t0 = cyc;
    rs1 = 1'b1; data1 = 8'h55;
    step();
    for (int i = 0; i < 200 && !ack1; i++) step();
    chk("s4_ack1_again", ack1, 1);
    chk("s4_long_gap", cyc - t0, W_LONG + 1);
    chk("s4_data2", lcd_data, 8'h55);
    req1 = 1'b0;
    for (int i = 0; i < 100 && busy; i++) step();
    chk("s4_idle", busy, 0);

    // Both requesters continuously asserting, random payloads.
    rs0 = 1'($urandom); data0 = rand_byte();
    rs1 = 1'($urandom); data1 = rand_byte();
    req0 = 1'b1; req1 = 1'b1;
    prev_ack = -1; exp_gap = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      for (int i = 0; i < 200 && !(ack0 || ack1); i++) step();
      chk($sformatf("rr_ack_seen%0d", k), ack0 | ack1, 1);
      who = ack1 ? 1 : 0;
      chk($sformatf("rr_order%0d", k), who, (m_last == 0) ? 1 : 0);
      exp_rs = (who == 1) ? rs1 : rs0;
      exp_d  = (who == 1) ? data1 : data0;
      chk($sformatf("rr_data%0d", k), lcd_data, exp_d);
      chk($sformatf("rr_rs%0d", k), lcd_rs, exp_rs);
      if (prev_ack >= 0) chk($sformatf("rr_gap%0d", k), cyc - prev_ack, exp_gap);
      exp_gap = P_SETUP + P_EN + P_HOLD + exec_len(exp_rs, exp_d) + 1;
      prev_ack = cyc;
      m_last = who;
      if (who == 1) begin rs1 = 1'($urandom); data1 = rand_byte(); end
      else          begin rs0 = 1'($urandom); data0 = rand_byte(); end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 200 && busy; i++) step();
    chk("rr_idle", busy, 0);

    // Reset in the middle of an enable pulse, with a request held through init.
    rs0 = 1'b1; data0 = rand_byte(); req0 = 1'b1;
    for (int i = 0; i < 50 && !ack0; i++) step();
    chk("s5_ack0", ack0, 1);
    for (int i = 0; i < 20 && !lcd_en; i++) step();
    chk("s5_in_pulse", lcd_en, 1);
    reset = 1'b1;
    #1;
    chk("s5_en_drop", lcd_en, 0);
    chk("s5_busy", busy, 1);
    chk("s5_init_done", init_done, 0);
    chk("s5_data", lcd_data, 0);
    m_last = 1;
    step(); step();
    clear_log();
    reset = 1'b0;
    for (int i = 0; i < 400 && !init_done; i++) step();
    chk("s6_init_done_seen", init_done, 1);
    chk("s6_init_done_cycle", cyc, T_INIT);
    chk("s6_no_ack_in_init", ack_cyc.size(), 0);
    check_init("reinit");
    step();
    chk("s6_ack0", ack0, 1);
    chk("s6_ack_cycle", cyc, T_INIT + 1);
    m_last = 0;
    req0 = 1'b0;
    for (int i = 0; i < 200 && busy; i++) step();
    chk("s6_idle", busy, 0);

    chk("rw_low", rw_bad, 0);
    chk("ack_exclusive", both_ack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
